// File: rtl/spi_frame_pkg.sv
// Shared frame layout and command codes for the SPI frame decoder.
package spi_frame_pkg;

  localparam int FRAME_W = 32;
  localparam int CMD_W   = 4;
  localparam int CNT_W   = 5;

  localparam int CMD_MSB  = 31;
  localparam int CMD_LSB  = 28;
  localparam int ADDR_MSB = 27;
  localparam int ADDR_LSB = 14;
  localparam int DATA_MSB = 13;
  localparam int DATA_LSB = 0;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP      = 4'h0,
    CMD_WRITE    = 4'h1,
    CMD_FGEN_ON  = 4'h2,
    CMD_FGEN_OFF = 4'h3
  } cmd_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the last two synchronized samples.
// Latency: level STAGES clk after the pin; edge pulses are one clk wide.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic IDLE   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{IDLE}};
      prev_q <= IDLE;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign lvl_o  = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_frame_decoder.sv
// SPI mode-0 slave decoding 32-bit command frames into waveform-memory writes and generator control.
// Latency: rx_valid/mem_we SYNC_STAGES+2 clk after the bit-32 SCK rise; no backpressure. Macro SPI_FRAME_ECHO_EN enables MISO echo.
module spi_frame_decoder
  import spi_frame_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SCK,
  input  logic               MOSI,
  input  logic               SSEL,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_frame,
  output logic               rx_valid,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_data,
  output logic               fgen_ena,
  output logic               frame_err,
  output logic [7:0]         err_cnt
);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_core_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_core_n = rst_sync_q[1];

  logic sck_lvl, sck_rise, sck_fall;
  logic ssel_lvl, ssel_rise, ssel_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_lvl;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_core_n), .din_i(SCK),
    .lvl_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_ssel_sync (
    .clk(clk), .rst_n(rst_core_n), .din_i(SSEL),
    .lvl_o(ssel_lvl), .rise_o(ssel_rise), .fall_o(ssel_fall)
  );

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) mosi_sync_q <= '0;
    else             mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_lvl = mosi_sync_q[SYNC_STAGES-1];

  logic [FRAME_W-2:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] rx_frame_q, rx_frame_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;

  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rx_frame_d = rx_frame_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    if (ssel_fall) begin
      cnt_d = '0;
    end else if (ssel_rise && cnt_q != '0) begin
      cnt_d   = '0;
      abort_d = 1'b1;
    end else if (sck_rise && !ssel_lvl) begin
      shift_d = {shift_q[FRAME_W-3:0], mosi_lvl};
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(FRAME_W-1)) begin
        rx_frame_d = {shift_q, mosi_lvl};
        done_d     = 1'b1;
      end
    end
  end

  // Command decode runs one clk after capture, aligned with rx_valid.
  cmd_e              cmd;
  logic              rx_valid_q, rx_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              fgen_q, fgen_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              err_hit;

  assign cmd = cmd_e'(rx_frame_q[CMD_MSB:CMD_LSB]);

  always_comb begin
    rx_valid_d = done_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    fgen_d     = fgen_q;
    err_hit    = abort_q;
    if (done_q) begin
      case (cmd)
        CMD_NOP:      ;
        CMD_WRITE: begin
          mem_we_d   = 1'b1;
          mem_addr_d = rx_frame_q[DATA_W +: ADDR_W];
          mem_data_d = rx_frame_q[DATA_W-1:0];
        end
        CMD_FGEN_ON:  fgen_d = 1'b1;
        CMD_FGEN_OFF: fgen_d = 1'b0;
        default:      err_hit = 1'b1;
      endcase
    end
    frame_err_d = err_hit;
    err_cnt_d   = (err_hit && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      rx_frame_q  <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      rx_valid_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      fgen_q      <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rx_frame_q  <= rx_frame_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      rx_valid_q  <= rx_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      fgen_q      <= fgen_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rx_frame  = rx_frame_q;
  assign rx_valid  = rx_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign fgen_ena  = fgen_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

  logic unused_ok;

`ifdef SPI_FRAME_ECHO_EN
  // Echo reloads at SSEL fall and again after every 32nd bit for back-to-back frames.
  logic [FRAME_W-1:0] echo_q, echo_d;

  always_comb begin
    echo_d = echo_q;
    if (ssel_fall)
      echo_d = rx_frame_q;
    else if (sck_fall && !ssel_lvl)
      echo_d = (cnt_q == '0) ? rx_frame_q : {echo_q[FRAME_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) echo_q <= '0;
    else             echo_q <= echo_d;
  end

  assign MISO      = echo_q[FRAME_W-1];
  assign unused_ok = sck_lvl;
`else
  assign MISO      = 1'b0;
  assign unused_ok = &{sck_lvl, sck_fall};
`endif

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed SPI frames with a queue scoreboard checked by an independent output monitor.
module tb_spi_frame_decoder;
  localparam int SYNC_STAGES = 2;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 14;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic SCK = 1'b0;
  logic MOSI = 1'b0;
  logic SSEL = 1'b1;
  logic MISO;
  logic [31:0] rx_frame;
  logic rx_valid, mem_we, fgen_ena, frame_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [7:0] err_cnt;

  spi_frame_decoder #(.SYNC_STAGES(SYNC_STAGES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .SCK(SCK), .MOSI(MOSI), .SSEL(SSEL), .MISO(MISO),
    .rx_frame(rx_frame), .rx_valid(rx_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .fgen_ena(fgen_ena), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int last_rise = 0;
  int errs = 0;
  logic [31:0] exp_frame_q[$];
  logic [27:0] exp_wr_q[$];
  logic [7:0]  exp_err_q[$];
  logic [13:0] sine [24];
  logic [31:0] echo_a, echo_exp, e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h, nothing expected", nm, act);
  endtask

  // Monitor: every output event pops the matching expectation.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_frame_q.size() == 0) flag("rx_valid_extra", rx_frame);
      else begin
        e = exp_frame_q.pop_front();
        chk("rx_frame", rx_frame, e);
        chk("rx_latency", cyc - last_rise, SYNC_STAGES + 2);
      end
    end
    if (mem_we) begin
      if (exp_wr_q.size() == 0) flag("mem_we_extra", {mem_addr, mem_data});
      else begin
        e = {4'h0, exp_wr_q.pop_front()};
        chk("mem_write", {4'h0, mem_addr, mem_data}, e);
      end
    end
    if (frame_err) begin
      if (exp_err_q.size() == 0) flag("frame_err_extra", err_cnt);
      else begin
        e = {24'h0, exp_err_q.pop_front()};
        chk("err_cnt", err_cnt, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sbit(input logic b, input logic chk_en, input logic expm);
    MOSI = b;
    tick(HALF);
    if (chk_en) chk("miso", MISO, expm);
    SCK = 1'b1;
    last_rise = cyc;
    tick(HALF);
    SCK = 1'b0;
  endtask

  task automatic send(input logic [31:0] f, input logic chk_en, input logic [31:0] ref_f);
    for (int i = 31; i >= 0; i--) sbit(f[i], chk_en, ref_f[i]);
  endtask

  task automatic bump_err();
    if (errs < 255) errs++;
    exp_err_q.push_back(8'(errs));
  endtask

  task automatic issue(input logic [31:0] f);
    exp_frame_q.push_back(f);
    if (f[31:28] > 4'h3) bump_err();
  endtask

  task automatic open_ssel();
    SSEL = 1'b0;
    tick(6);
  endtask

  task automatic close_ssel();
    tick(6);
    SSEL = 1'b1;
    tick(8);
  endtask

  task automatic abort_frame(input int nbits);
    open_ssel();
    for (int i = 0; i < nbits; i++) sbit(i[0], 1'b0, 1'b0);
    bump_err();
    close_ssel();
  endtask

  task automatic chk_all_zero();
    chk("rst_rx_frame", rx_frame, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_fgen_ena", fgen_ena, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_miso", MISO, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sine = '{14'd8192, 14'd10312, 14'd12288, 14'd13984, 14'd15286, 14'd16104,
             14'd16383, 14'd16104, 14'd15286, 14'd13984, 14'd12288, 14'd10312,
             14'd8192, 14'd6072, 14'd4096, 14'd2400, 14'd1098, 14'd280,
             14'd1, 14'd280, 14'd1098, 14'd2400, 14'd4096, 14'd6072};
    #2 rst_n = 1'b0;
    tick(3);
    chk_all_zero();
    rst_n = 1'b1;
    tick(6);

    // Single write: addr 1, data 0x1FFF.
    open_ssel();
    exp_wr_q.push_back({14'd1, 14'h1FFF});
    issue(32'h1000_5FFF);
    send(32'h1000_5FFF, 1'b0, 32'h0);
    close_ssel();

    // 24 back-to-back sine writes then generator on, one SSEL window.
    open_ssel();
    for (int i = 0; i < 24; i++) begin
      exp_wr_q.push_back({14'(i), sine[i]});
      issue({4'h1, 14'(i), sine[i]});
      send({4'h1, 14'(i), sine[i]}, 1'b0, 32'h0);
    end
    issue(32'h2000_0000);
    send(32'h2000_0000, 1'b0, 32'h0);
    close_ssel();
    chk("fgen_on", fgen_ena, 1);
    chk("hold_addr", mem_addr, 23);
    chk("hold_data", mem_data, 14'd6072);

    // Unknown command leaves fgen alone; then generator off.
    open_ssel();
    issue(32'h7000_0000);
    send(32'h7000_0000, 1'b0, 32'h0);
    close_ssel();
    chk("fgen_after_err", fgen_ena, 1);
    open_ssel();
    issue(32'h3000_0000);
    send(32'h3000_0000, 1'b0, 32'h0);
    close_ssel();
    chk("fgen_off", fgen_ena, 0);

    // Partial frame of 17 bits, then a full frame at the address/data extremes.
    abort_frame(17);
    open_ssel();
    exp_wr_q.push_back({14'h3FFF, 14'h0001});
    issue(32'h1FFF_C001);
    send(32'h1FFF_C001, 1'b0, 32'h0);
    close_ssel();

    // Mid-frame reset after enabling the generator.
    open_ssel();
    issue(32'h2000_0000);
    send(32'h2000_0000, 1'b0, 32'h0);
    tick(6);
    chk("fgen_pre_rst", fgen_ena, 1);
    chk("errcnt_pre_rst", err_cnt, 2);
    for (int i = 31; i >= 22; i--) sbit(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all_zero();
    tick(3);
    SSEL = 1'b1;
    rst_n = 1'b1;
    errs = 0;
    tick(8);
    open_ssel();
    exp_wr_q.push_back({14'd5, 14'h2AAA});
    issue(32'h1001_6AAA);
    send(32'h1001_6AAA, 1'b0, 32'h0);
    close_ssel();

    // MISO: second frame must echo the first (or stay 0 without echo).
    echo_a = 32'h0ABC_1234;
`ifdef SPI_FRAME_ECHO_EN
    echo_exp = echo_a;
`else
    echo_exp = 32'h0;
`endif
    open_ssel();
    issue(echo_a);
    send(echo_a, 1'b0, 32'h0);
    close_ssel();
    open_ssel();
    issue(32'h0000_0000);
    send(32'h0000_0000, 1'b1, echo_exp);
    close_ssel();

    // Error counter saturation.
    for (int k = 0; k < 256; k++) abort_frame(1);
    tick(10);
    chk("err_saturated", err_cnt, 255);
    chk("frames_left", exp_frame_q.size(), 0);
    chk("writes_left", exp_wr_q.size(), 0);
    chk("errs_left", exp_err_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
